// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory data types, FSM states and
// the access-size helper.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    DT_BYTE  = 3'd0,
    DT_UBYTE = 3'd1,
    DT_HALF  = 3'd2,
    DT_UHALF = 3'd3,
    DT_WORD  = 3'd4
  } mem_dt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Unknown encodings fall through to a full word access.
  function automatic logic [2:0] size_of(input mem_dt_e dt);
    case (dt)
      DT_BYTE, DT_UBYTE: size_of = 3'd1;
      DT_HALF, DT_UHALF: size_of = 3'd2;
      default:           size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide data memory port of the LSU.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  import load_store_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  mem_dt_e           req_dt;
  logic              req_we;
  logic [31:0]       req_wd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rd;
  logic              rsp_split;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wd;
  logic [3:0]        m_be;
  logic              m_we;
  logic [31:0]       m_rd;

  modport master (
    output req_valid, req_addr, req_dt, req_we, req_wd, rsp_ready, m_rd,
    input  req_ready, rsp_valid, rsp_rd, rsp_split, m_addr, m_wd, m_be, m_we
  );

  modport slave (
    input  req_valid, req_addr, req_dt, req_we, req_wd, rsp_ready, m_rd,
    output req_ready, rsp_valid, rsp_rd, rsp_split, m_addr, m_wd, m_be, m_we
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables for both accesses, split detection,
// store-data rotation and load merge with sign/zero extension.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  mem_dt_e     dt,
  input  logic [31:0] wd,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic        split,
  output logic [31:0] wd_rot,
  output logic [31:0] rd
);

  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [1:0]  src;
  logic [2:0]  pos;
  logic [31:0] raw;

  // Lanes spilling past lane 3 land in the low lanes of the next word.
  always_comb begin
    size = size_of(dt);
    case (size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << off;
    be0       = lane_mask[3:0];
    be1       = lane_mask[7:4];
    split     = |be1;
  end

  always_comb begin
    wd_rot = '0;
    raw    = '0;
    src    = '0;
    pos    = '0;
    for (int k = 0; k < 4; k++) begin
      src = 2'(k) - off;
      wd_rot[8*k +: 8] = wd[{src, 3'b000} +: 8];
      pos = 3'(k) + {1'b0, off};
      raw[8*k +: 8] = pos[2] ? word1[{pos[1:0], 3'b000} +: 8]
                             : word0[{pos[1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    case (dt)
      DT_BYTE:  rd = {{24{raw[7]}}, raw[7:0]};
      DT_UBYTE: rd = {24'b0, raw[7:0]};
      DT_HALF:  rd = {{16{raw[15]}}, raw[15:0]};
      DT_UHALF: rd = {16'b0, raw[15:0]};
      default:  rd = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front-end: accepts one request, issues one or two word accesses
// (splitting across 32-bit boundaries) and returns the extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e        state;
  lsu_state_e        state_next;
  logic [ADDR_W-1:0] addr_q;
  mem_dt_e           dt_q;
  logic              we_q;
  logic [31:0]       wd_q;
  logic [31:0]       word0_q;
  logic [31:0]       word1_q;

  logic [3:0]        be0;
  logic [3:0]        be1;
  logic              split;
  logic [31:0]       wd_rot;
  logic [31:0]       rd_merged;
  logic [ADDR_W-1:0] base_addr;

  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

  load_store_unit_align u_align (
    .off    (addr_q[1:0]),
    .dt     (dt_q),
    .wd     (wd_q),
    .word0  (word0_q),
    .word1  (word1_q),
    .be0    (be0),
    .be1    (be1),
    .split  (split),
    .wd_rot (wd_rot),
    .rd     (rd_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      dt_q    <= DT_WORD;
      we_q    <= 1'b0;
      wd_q    <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        dt_q   <= bus.req_dt;
        we_q   <= bus.req_we;
        wd_q   <= bus.req_wd;
      end
      if (state == ST_ACC0) begin
        word0_q <= bus.m_rd;
      end
      if (state == ST_ACC1) begin
        word1_q <= bus.m_rd;
      end
    end
  end

  // Memory strobes exist only in the access states, so an async reset kills m_we at once.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rd    = '0;
    bus.rsp_split = 1'b0;
    bus.m_addr    = '0;
    bus.m_wd      = '0;
    bus.m_be      = '0;
    bus.m_we      = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = ST_ACC0;
        end
      end
      ST_ACC0: begin
        bus.m_addr = base_addr;
        bus.m_wd   = wd_rot;
        bus.m_be   = be0;
        bus.m_we   = we_q;
        state_next = split ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        bus.m_addr = base_addr + ADDR_W'(4);
        bus.m_wd   = wd_rot;
        bus.m_be   = be1;
        bus.m_we   = we_q;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rd    = we_q ? 32'h0 : rd_merged;
        bus.rsp_split = split;
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table of single requests
// against a small word memory, plus wrap, backpressure and mid-access reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int ADDR_W = 32;
  localparam int NVEC   = 14;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  dt;
    logic        we;
    logic [31:0] wd;
    logic [31:0] init0;
    logic [31:0] init1;
    logic [31:0] exp_rd;
    logic        exp_split;
    logic [31:0] exp_m0;
    logic [31:0] exp_m1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  int          checks;
  int          errors;
  vec_t        vecs [NVEC];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.m_rd = mem[bus.m_addr[7:2]];

  // Memory model: preload port has priority, otherwise enabled lanes are written.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.m_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.m_be[i]) begin
          mem[bus.m_addr[7:2]][8*i +: 8] <= bus.m_wd[8*i +: 8];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] dt, input logic we,
                               input logic [31:0] wd, output logic [31:0] rd,
                               output logic split, output int cycle);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_dt    = mem_dt_e'(dt);
    bus.req_we    = we;
    bus.req_wd    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cycle = 1;
    while (bus.rsp_valid !== 1'b1 && cycle < 12) begin
      @(posedge clk);
      #1;
      cycle++;
    end
    rd    = bus.rsp_rd;
    split = bus.rsp_split;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        split;
    int          cycle;

    checks        = 0;
    errors        = 0;
    pre_en        = 1'b0;
    pre_idx       = '0;
    pre_val       = '0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_dt    = DT_WORD;
    bus.req_we    = 1'b0;
    bus.req_wd    = '0;
    bus.rsp_ready = 1'b0;

    //          addr    dt    we    wd            init0         init1         exp_rd        split exp_m0        exp_m1
    vecs[0]  = '{32'd50, 3'd2, 1'b1, 32'h0000dead, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, 32'hdead5678, 32'h9abcdef0};
    vecs[1]  = '{32'd48, 3'd2, 1'b0, 32'h0,        32'h82848688, 32'h00000000, 32'hffff8688, 1'b0, 32'h82848688, 32'h00000000};
    vecs[2]  = '{32'd48, 3'd3, 1'b0, 32'h0,        32'h82848688, 32'h00000000, 32'h00008688, 1'b0, 32'h82848688, 32'h00000000};
    vecs[3]  = '{32'd49, 3'd4, 1'b0, 32'h0,        32'h44332211, 32'h88776655, 32'h55443322, 1'b1, 32'h44332211, 32'h88776655};
    vecs[4]  = '{32'd51, 3'd2, 1'b1, 32'h0000beef, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1, 32'hef345678, 32'h9abcdebe};
    vecs[5]  = '{32'd51, 3'd0, 1'b0, 32'h0,        32'h80aabbcc, 32'h00000000, 32'hffffff80, 1'b0, 32'h80aabbcc, 32'h00000000};
    vecs[6]  = '{32'd49, 3'd1, 1'b0, 32'h0,        32'h80aabbcc, 32'h00000000, 32'h000000bb, 1'b0, 32'h80aabbcc, 32'h00000000};
    vecs[7]  = '{32'd51, 3'd2, 1'b0, 32'h0,        32'h80aabbcc, 32'h11223344, 32'h00004480, 1'b1, 32'h80aabbcc, 32'h11223344};
    vecs[8]  = '{32'd50, 3'd4, 1'b1, 32'ha1b2c3d4, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 32'hc3d40000, 32'h0000a1b2};
    vecs[9]  = '{32'd53, 3'd0, 1'b1, 32'h123456ff, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 32'h11111111, 32'h2222ff22};
    vecs[10] = '{32'd52, 3'd4, 1'b0, 32'h0,        32'h00000000, 32'hcafef00d, 32'hcafef00d, 1'b0, 32'h00000000, 32'hcafef00d};
    vecs[11] = '{32'd50, 3'd7, 1'b0, 32'h0,        32'h44332211, 32'h88776655, 32'h66554433, 1'b1, 32'h44332211, 32'h88776655};
    vecs[12] = '{32'd54, 3'd2, 1'b0, 32'h0,        32'h00000000, 32'h7fff1234, 32'h00007fff, 1'b0, 32'h00000000, 32'h7fff1234};
    vecs[13] = '{32'd48, 3'd0, 1'b1, 32'hffffffaa, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, 32'h123456aa, 32'h9abcdef0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_rd",    bus.rsp_rd,         32'h0);
    checkOutput("reset_rsp_split", 32'(bus.rsp_split), 32'h0);
    checkOutput("reset_m_we",      32'(bus.m_we),      32'h0);
    checkOutput("reset_m_be",      32'(bus.m_be),      32'h0);
    checkOutput("reset_m_addr",    bus.m_addr,         32'h0);
    checkOutput("reset_m_wd",      bus.m_wd,           32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      preload(6'd12, vecs[i].init0);
      preload(6'd13, vecs[i].init1);
      applyStimulus(vecs[i].addr, vecs[i].dt, vecs[i].we, vecs[i].wd, rd, split, cycle);
      checkOutput($sformatf("vec%0d_rd", i),      rd,            vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_split", i),   32'(split),    32'(vecs[i].exp_split));
      checkOutput($sformatf("vec%0d_latency", i), 32'(cycle),    vecs[i].exp_split ? 32'd3 : 32'd2);
      checkOutput($sformatf("vec%0d_mem12", i),   mem[12],       vecs[i].exp_m0);
      checkOutput($sformatf("vec%0d_mem13", i),   mem[13],       vecs[i].exp_m1);
    end

    // Split word load at the top of the address space wraps to address 0.
    preload(6'd63, 32'h44332211);
    preload(6'd0,  32'h88776655);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hfffffffe;
    bus.req_dt    = DT_WORD;
    bus.req_we    = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    checkOutput("wrap_acc0_addr", bus.m_addr,    32'hfffffffc);
    checkOutput("wrap_acc0_be",   32'(bus.m_be), 32'hc);
    @(posedge clk);
    #1;
    checkOutput("wrap_acc1_addr", bus.m_addr,    32'h00000000);
    checkOutput("wrap_acc1_be",   32'(bus.m_be), 32'h3);
    @(posedge clk);
    #1;
    checkOutput("wrap_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("wrap_rsp_rd",    bus.rsp_rd,         32'h66554433);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;

    // Backpressure: response held while a second request waits unaccepted.
    preload(6'd12, 32'h82848688);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd48;
    bus.req_dt    = DT_HALF;
    bus.req_we    = 1'b0;
    @(posedge clk);
    #1;
    bus.req_addr  = 32'd52;
    bus.req_dt    = DT_WORD;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h1);
      checkOutput($sformatf("bp%0d_rsp_rd", c),    bus.rsp_rd,         32'hffff8688);
      checkOutput($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checkOutput("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("bp_release_req_ready", 32'(bus.req_ready), 32'h1);

    // Reset during the second access of a split store: first word stays written.
    preload(6'd12, 32'h00000000);
    preload(6'd13, 32'h00000000);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd51;
    bus.req_dt    = DT_HALF;
    bus.req_we    = 1'b1;
    bus.req_wd    = 32'h0000beef;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_acc1_m_we",   32'(bus.m_we), 32'h1);
    checkOutput("rst_acc1_m_addr", bus.m_addr,    32'd52);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_m_we",      32'(bus.m_we),      32'h0);
    checkOutput("rst_async_m_be",      32'(bus.m_be),      32'h0);
    checkOutput("rst_async_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mem12_kept",  mem[12],             32'hef000000);
    checkOutput("rst_mem13_clean", mem[13],             32'h00000000);
    checkOutput("rst_rsp_valid",   32'(bus.rsp_valid),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
